// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file access sequencer: state encoding,
// register-file address map and field widths also used by decode and the register file.
package regfile_seq_pkg;

  localparam int PC_IDX     = 7;
  localparam int CONST_BASE = 8;

  // Register index field (R0-R7) and full register-file select (bank bit + index)
  localparam int REG_IDX_W = 3;
  localparam int RF_SEL_W  = REG_IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SRC,
    S_RD_DST,
    S_CAP,
    S_WAIT_RES,
    S_WRITE,
    S_INC
  } state_t;

  // Bank bit selects the constant table (regnum CONST_BASE + idx)
  function automatic logic [RF_SEL_W-1:0] rf_sel(input logic use_const,
                                                 input logic [REG_IDX_W-1:0] idx);
    return {use_const, idx};
  endfunction

endpackage

// File: rtl/regfile_seq.sv
// Register-file access sequencer: serialises source read, destination read,
// ALU handshake, optional write-back and PC increment through one register-file port.
module regfile_seq
  import regfile_seq_pkg::*;
#(
  parameter int DW     = 16,
  parameter int RNW    = 8,
  parameter int PC_IDX = regfile_seq_pkg::PC_IDX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 ready,
  input  logic                 src_en,
  input  logic                 rc,
  input  logic [REG_IDX_W-1:0] src,
  input  logic [REG_IDX_W-1:0] dst,
  input  logic                 wb_en,
  output logic [DW-1:0]        src_val,
  output logic [DW-1:0]        dst_val,
  output logic                 ops_valid,
  input  logic                 res_valid,
  input  logic [DW-1:0]        res_data,
  output logic                 done,
  output logic [RNW-1:0]       rf_regnum,
  output logic                 rf_rw,
  output logic [DW-1:0]        rf_datain,
  output logic                 rf_inc,
  input  logic [DW-1:0]        rf_dataout
);

  state_t state, state_nx;

  logic                 src_en_q;
  logic                 rc_q;
  logic [REG_IDX_W-1:0] src_q;
  logic [REG_IDX_W-1:0] dst_q;
  logic                 wb_q;

  logic dst_is_pc;
  assign dst_is_pc = (dst_q == REG_IDX_W'(PC_IDX));

  // Instruction fields: pure data, loaded only when a start is accepted
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      src_en_q <= src_en;
      rc_q     <= rc;
      src_q    <= src;
      dst_q    <= dst;
      wb_q     <= wb_en;
    end
  end

  // Sequencer state and visible operand/result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      src_val   <= '0;
      dst_val   <= '0;
      rf_datain <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start && !src_en) src_val <= '0;
        end
        S_RD_DST: begin
          if (src_en_q) src_val <= rf_dataout;
        end
        S_CAP: begin
          dst_val <= rf_dataout;
        end
        S_WAIT_RES: begin
          if (res_valid) rf_datain <= res_data;
        end
        default: ;
      endcase
    end
  end

  // Next state and Moore outputs; port is parked at regnum 0 / read when unused
  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    ops_valid = 1'b0;
    done      = 1'b0;
    rf_regnum = '0;
    rf_rw     = 1'b0;
    rf_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nx = src_en ? S_RD_SRC : S_RD_DST;
      end
      S_RD_SRC: begin
        rf_regnum = {{(RNW-RF_SEL_W){1'b0}}, rf_sel(rc_q, src_q)};
        state_nx  = S_RD_DST;
      end
      S_RD_DST: begin
        rf_regnum = {{(RNW-REG_IDX_W){1'b0}}, dst_q};
        state_nx  = S_CAP;
      end
      S_CAP: begin
        state_nx = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        ops_valid = 1'b1;
        if (res_valid) state_nx = wb_q ? S_WRITE : S_INC;
      end
      S_WRITE: begin
        rf_rw     = 1'b1;
        rf_regnum = {{(RNW-REG_IDX_W){1'b0}}, dst_q};
        // A write to the PC already redirects it, so the +2 step is skipped
        if (dst_is_pc) begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end else begin
          state_nx = S_INC;
        end
      end
      S_INC: begin
        rf_inc   = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  a_rw_inc_exclusive: assert property (@(posedge clk) disable iff (rst) !(rf_rw && rf_inc));

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: a register-file model answers the port, and an
// architectural register model predicts operands, write-back and PC updates.
module tb_regfile_seq;

  localparam int DW  = 16;
  localparam int RNW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           ready;
  logic           src_en = 1'b0;
  logic           rc = 1'b0;
  logic [2:0]     src = '0;
  logic [2:0]     dst = '0;
  logic           wb_en = 1'b0;
  logic [DW-1:0]  src_val;
  logic [DW-1:0]  dst_val;
  logic           ops_valid;
  logic           res_valid = 1'b0;
  logic [DW-1:0]  res_data = '0;
  logic           done;
  logic [RNW-1:0] rf_regnum;
  logic           rf_rw;
  logic [DW-1:0]  rf_datain;
  logic           rf_inc;
  logic [DW-1:0]  rf_dataout;

  int n_pass  = 0;
  int n_total = 0;

  regfile_seq #(.DW(DW), .RNW(RNW), .PC_IDX(7)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .src_en(src_en), .rc(rc), .src(src), .dst(dst), .wb_en(wb_en),
    .src_val(src_val), .dst_val(dst_val), .ops_valid(ops_valid),
    .res_valid(res_valid), .res_data(res_data), .done(done),
    .rf_regnum(rf_regnum), .rf_rw(rf_rw), .rf_datain(rf_datain),
    .rf_inc(rf_inc), .rf_dataout(rf_dataout)
  );

  always #5 clk = ~clk;

  // Register-file environment: R0-R7 plus a read-only constant table at 8-15
  logic [DW-1:0] rf_mem [8];
  logic          rf_load = 1'b0;
  logic [DW-1:0] model_r [8];

  function automatic logic [DW-1:0] ctab(input logic [2:0] i);
    case (i)
      3'd0: return 16'h0000;
      3'd1: return 16'h0001;
      3'd2: return 16'h0002;
      3'd3: return 16'h0004;
      3'd4: return 16'h0008;
      3'd5: return 16'h0010;
      3'd6: return 16'h8000;
      default: return 16'hFFFF;
    endcase
  endfunction

  function automatic logic [DW-1:0] init_val(input int i);
    case (i)
      0: return 16'hA5A5;
      1: return 16'h0001;
      2: return 16'h1234;
      3: return 16'h0F0F;
      4: return 16'h4444;
      5: return 16'h5555;
      6: return 16'h6666;
      default: return 16'h0200;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= init_val(i);
    end else begin
      if (rf_rw) rf_mem[rf_regnum[2:0]] <= rf_datain;
      if (rf_inc) rf_mem[7] <= rf_mem[7] + 16'd2;
    end
    rf_dataout <= rf_regnum[3] ? ctab(rf_regnum[2:0]) : rf_mem[rf_regnum[2:0]];
  end

  // Architectural expectations
  function automatic logic [DW-1:0] exp_src(input logic se, input logic r, input logic [2:0] s);
    if (!se) return '0;
    return r ? ctab(s) : model_r[s];
  endfunction

  task automatic retire_model(input logic [2:0] d, input logic wb, input logic [DW-1:0] res);
    if (wb) model_r[d] = res;
    if (!(wb && d == 3'd7)) model_r[7] = model_r[7] + 16'd2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction; returns cycles from acceptance to ops_valid and the first regnum driven
  task automatic issue(input logic se, input logic r, input logic [2:0] s, input logic [2:0] d,
                       input logic wb, output int lat, output logic [RNW-1:0] first_regnum);
    int k;
    k = 0;
    while (!ready && k < 20) begin
      step();
      k++;
    end
    src_en = se; rc = r; src = s; dst = d; wb_en = wb; start = 1'b1;
    step();
    start = 1'b0;
    src_en = 1'($urandom); rc = 1'($urandom); src = 3'($urandom); dst = 3'($urandom);
    wb_en = 1'($urandom);
    first_regnum = rf_regnum;
    k = 1;
    while (!ops_valid && k < 12) begin
      step();
      k++;
    end
    lat = ops_valid ? k : -1;
  endtask

  task automatic give_result(input logic [DW-1:0] r, input int delay);
    repeat (delay) step();
    res_valid = 1'b1;
    res_data  = r;
    step();
    res_valid = 1'b0;
    res_data  = 16'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rf_load = 1'b1;
    repeat (3) step();
    rf_load = 1'b0;
    for (int i = 0; i < 8; i++) model_r[i] = init_val(i);
    n_total++; if (ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", ready); else n_pass++;
    n_total++; if (ops_valid !== 1'b0) $display("FAIL rst_ops_valid: got %b expected 0", ops_valid); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else n_pass++;
    n_total++; if (rf_rw !== 1'b0) $display("FAIL rst_rw: got %b expected 0", rf_rw); else n_pass++;
    n_total++; if (rf_inc !== 1'b0) $display("FAIL rst_inc: got %b expected 0", rf_inc); else n_pass++;
    n_total++; if (rf_regnum !== 8'd0) $display("FAIL rst_regnum: got %h expected 00", rf_regnum); else n_pass++;
    n_total++; if (rf_datain !== 16'd0) $display("FAIL rst_datain: got %h expected 0000", rf_datain); else n_pass++;
    n_total++; if (src_val !== 16'd0) $display("FAIL rst_src_val: got %h expected 0000", src_val); else n_pass++;
    n_total++; if (dst_val !== 16'd0) $display("FAIL rst_dst_val: got %h expected 0000", dst_val); else n_pass++;
    rst = 1'b0;
    step();
    n_total++; if (ready !== 1'b1) $display("FAIL idle_ready: got %b expected 1", ready); else n_pass++;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (rf_mem[i] !== model_r[i])
        $display("FAIL %s_R%0d: got %h expected %h", tag, i, rf_mem[i], model_r[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reg_src_wb();
    int lat;
    logic [RNW-1:0] fr;
    logic [DW-1:0] es, ed;
    es = exp_src(1'b1, 1'b0, 3'd2);
    ed = model_r[3];
    issue(1'b1, 1'b0, 3'd2, 3'd3, 1'b1, lat, fr);
    n_total++; if (lat !== 4) $display("FAIL reg_lat: got %0d expected 4", lat); else n_pass++;
    n_total++; if (fr !== 8'd2) $display("FAIL reg_src_regnum: got %h expected 02", fr); else n_pass++;
    n_total++; if (src_val !== es) $display("FAIL reg_src_val: got %h expected %h", src_val, es); else n_pass++;
    n_total++; if (dst_val !== ed) $display("FAIL reg_dst_val: got %h expected %h", dst_val, ed); else n_pass++;
    give_result(16'h2143, 0);
    n_total++; if (rf_rw !== 1'b1) $display("FAIL reg_wr_rw: got %b expected 1", rf_rw); else n_pass++;
    n_total++; if (rf_regnum !== 8'd3) $display("FAIL reg_wr_regnum: got %h expected 03", rf_regnum); else n_pass++;
    n_total++; if (rf_datain !== 16'h2143) $display("FAIL reg_wr_data: got %h expected 2143", rf_datain); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reg_wr_done: got %b expected 0", done); else n_pass++;
    step();
    n_total++; if (rf_inc !== 1'b1) $display("FAIL reg_inc: got %b expected 1", rf_inc); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL reg_done: got %b expected 1", done); else n_pass++;
    n_total++; if (rf_rw !== 1'b0) $display("FAIL reg_inc_rw: got %b expected 0", rf_rw); else n_pass++;
    retire_model(3'd3, 1'b1, 16'h2143);
    step();
    n_total++; if (ready !== 1'b1) $display("FAIL reg_ready_after: got %b expected 1", ready); else n_pass++;
    check_mem("reg");
  endtask

  task automatic test_const_no_wb();
    int lat;
    logic [RNW-1:0] fr;
    logic [DW-1:0] es, ed;
    es = exp_src(1'b1, 1'b1, 3'd7);
    ed = model_r[5];
    issue(1'b1, 1'b1, 3'd7, 3'd5, 1'b0, lat, fr);
    n_total++; if (lat !== 4) $display("FAIL const_lat: got %0d expected 4", lat); else n_pass++;
    n_total++; if (fr !== 8'd15) $display("FAIL const_regnum: got %h expected 0f", fr); else n_pass++;
    n_total++; if (src_val !== es) $display("FAIL const_src_val: got %h expected %h", src_val, es); else n_pass++;
    n_total++; if (dst_val !== ed) $display("FAIL const_dst_val: got %h expected %h", dst_val, ed); else n_pass++;
    give_result(16'h3C3C, 2);
    n_total++; if (rf_inc !== 1'b1) $display("FAIL const_inc: got %b expected 1", rf_inc); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL const_done: got %b expected 1", done); else n_pass++;
    n_total++; if (rf_rw !== 1'b0) $display("FAIL const_rw: got %b expected 0", rf_rw); else n_pass++;
    retire_model(3'd5, 1'b0, 16'h3C3C);
    step();
    check_mem("const");
  endtask

  task automatic test_pc_dest();
    int lat;
    logic [RNW-1:0] fr;
    logic [DW-1:0] ed;
    ed = model_r[7];
    issue(1'b0, 1'b0, 3'd3, 3'd7, 1'b1, lat, fr);
    n_total++; if (lat !== 3) $display("FAIL pc_lat: got %0d expected 3", lat); else n_pass++;
    n_total++; if (fr !== 8'd7) $display("FAIL pc_first_regnum: got %h expected 07", fr); else n_pass++;
    n_total++; if (src_val !== 16'h0000) $display("FAIL pc_src_val: got %h expected 0000", src_val); else n_pass++;
    n_total++; if (dst_val !== ed) $display("FAIL pc_dst_val: got %h expected %h", dst_val, ed); else n_pass++;
    give_result(16'h0100, 1);
    n_total++; if (rf_rw !== 1'b1) $display("FAIL pc_wr_rw: got %b expected 1", rf_rw); else n_pass++;
    n_total++; if (rf_regnum !== 8'd7) $display("FAIL pc_wr_regnum: got %h expected 07", rf_regnum); else n_pass++;
    n_total++; if (rf_datain !== 16'h0100) $display("FAIL pc_wr_data: got %h expected 0100", rf_datain); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL pc_done: got %b expected 1", done); else n_pass++;
    n_total++; if (rf_inc !== 1'b0) $display("FAIL pc_wr_inc: got %b expected 0", rf_inc); else n_pass++;
    step();
    n_total++; if (rf_inc !== 1'b0) $display("FAIL pc_no_inc: got %b expected 0", rf_inc); else n_pass++;
    n_total++; if (ready !== 1'b1) $display("FAIL pc_ready: got %b expected 1", ready); else n_pass++;
    retire_model(3'd7, 1'b1, 16'h0100);
    check_mem("pc");
  endtask

  task automatic test_busy();
    logic [DW-1:0] es, ed;
    es = exp_src(1'b1, 1'b0, 3'd4);
    ed = model_r[6];
    // res_valid already high while the operands are still being fetched
    res_valid = 1'b1; res_data = 16'hDEAD;
    src_en = 1'b1; rc = 1'b0; src = 3'd4; dst = 3'd6; wb_en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    n_total++; if (ops_valid !== 1'b0) $display("FAIL busy_cap_ops: got %b expected 0", ops_valid); else n_pass++;
    res_valid = 1'b0;
    step();
    n_total++; if (ops_valid !== 1'b1) $display("FAIL busy_ops_n4: got %b expected 1", ops_valid); else n_pass++;
    step();
    n_total++; if (ops_valid !== 1'b1) $display("FAIL busy_ops_hold: got %b expected 1", ops_valid); else n_pass++;
    n_total++; if (rf_rw !== 1'b0) $display("FAIL busy_early_rw: got %b expected 0", rf_rw); else n_pass++;
    src_en = 1'b0; rc = 1'b1; src = 3'd1; dst = 3'd2; wb_en = 1'b0; start = 1'b1;
    step();
    step();
    start = 1'b0;
    n_total++; if (ready !== 1'b0) $display("FAIL busy_ready: got %b expected 0", ready); else n_pass++;
    n_total++; if (ops_valid !== 1'b1) $display("FAIL busy_ops_after_start: got %b expected 1", ops_valid); else n_pass++;
    n_total++; if (src_val !== es) $display("FAIL busy_src_val: got %h expected %h", src_val, es); else n_pass++;
    n_total++; if (dst_val !== ed) $display("FAIL busy_dst_val: got %h expected %h", dst_val, ed); else n_pass++;
    give_result(16'h7777, 0);
    n_total++; if (rf_rw !== 1'b1) $display("FAIL busy_wr_rw: got %b expected 1", rf_rw); else n_pass++;
    n_total++; if (rf_regnum !== 8'd6) $display("FAIL busy_wr_regnum: got %h expected 06", rf_regnum); else n_pass++;
    n_total++; if (rf_datain !== 16'h7777) $display("FAIL busy_wr_data: got %h expected 7777", rf_datain); else n_pass++;
    step();
    n_total++; if (rf_inc !== 1'b1) $display("FAIL busy_inc: got %b expected 1", rf_inc); else n_pass++;
    retire_model(3'd6, 1'b1, 16'h7777);
    step();
    check_mem("busy");
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [RNW-1:0] fr;
    // Reset while waiting, with a result arriving in the same cycle
    issue(1'b1, 1'b0, 3'd1, 3'd4, 1'b1, lat, fr);
    n_total++; if (lat !== 4) $display("FAIL rwait_lat: got %0d expected 4", lat); else n_pass++;
    res_valid = 1'b1; res_data = 16'hBEEF; rst = 1'b1;
    step();
    rst = 1'b0; res_valid = 1'b0;
    n_total++; if (ready !== 1'b1) $display("FAIL rwait_ready: got %b expected 1", ready); else n_pass++;
    n_total++; if (ops_valid !== 1'b0) $display("FAIL rwait_ops: got %b expected 0", ops_valid); else n_pass++;
    n_total++; if (rf_rw !== 1'b0) $display("FAIL rwait_rw: got %b expected 0", rf_rw); else n_pass++;
    n_total++; if (src_val !== 16'd0) $display("FAIL rwait_src_val: got %h expected 0000", src_val); else n_pass++;
    n_total++; if (rf_datain !== 16'd0) $display("FAIL rwait_datain: got %h expected 0000", rf_datain); else n_pass++;
    step();
    n_total++; if (rf_rw !== 1'b0 || rf_inc !== 1'b0)
      $display("FAIL rwait_no_pulse: got rw=%b inc=%b expected 0 0", rf_rw, rf_inc); else n_pass++;
    check_mem("rwait");
    // Reset during the write cycle: that write is on the port, the increment never follows
    issue(1'b1, 1'b0, 3'd2, 3'd5, 1'b1, lat, fr);
    give_result(16'hCAFE, 0);
    n_total++; if (rf_rw !== 1'b1) $display("FAIL rwr_rw: got %b expected 1", rf_rw); else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_r[5] = 16'hCAFE;
    n_total++; if (ready !== 1'b1) $display("FAIL rwr_ready: got %b expected 1", ready); else n_pass++;
    n_total++; if (rf_inc !== 1'b0) $display("FAIL rwr_inc: got %b expected 0", rf_inc); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rwr_done: got %b expected 0", done); else n_pass++;
    n_total++; if (rf_rw !== 1'b0) $display("FAIL rwr_rw_after: got %b expected 0", rf_rw); else n_pass++;
    step();
    n_total++; if (rf_inc !== 1'b0) $display("FAIL rwr_inc_late: got %b expected 0", rf_inc); else n_pass++;
    check_mem("rwr");
  endtask

  task automatic test_random();
    int lat, dly;
    logic [RNW-1:0] fr, efr;
    logic se, r, wb;
    logic [2:0] s, d;
    logic [DW-1:0] es, ed, res;
    for (int it = 0; it < 30; it++) begin
      se = 1'($urandom); r = 1'($urandom); wb = 1'($urandom);
      s = 3'($urandom); d = 3'($urandom); res = 16'($urandom);
      dly = $urandom_range(0, 3);
      es = exp_src(se, r, s);
      ed = model_r[d];
      efr = se ? RNW'({r, s}) : RNW'(d);
      issue(se, r, s, d, wb, lat, fr);
      n_total++; if (lat !== (se ? 4 : 3)) $display("FAIL rnd%0d_lat: got %0d expected %0d", it, lat, se ? 4 : 3); else n_pass++;
      n_total++; if (fr !== efr) $display("FAIL rnd%0d_regnum: got %h expected %h", it, fr, efr); else n_pass++;
      n_total++; if (src_val !== es) $display("FAIL rnd%0d_src_val: got %h expected %h", it, src_val, es); else n_pass++;
      n_total++; if (dst_val !== ed) $display("FAIL rnd%0d_dst_val: got %h expected %h", it, dst_val, ed); else n_pass++;
      give_result(res, dly);
      if (wb) begin
        n_total++;
        if (rf_rw !== 1'b1 || rf_regnum !== RNW'(d) || rf_datain !== res || done !== (d == 3'd7) || rf_inc !== 1'b0)
          $display("FAIL rnd%0d_write: got rw=%b reg=%h data=%h done=%b inc=%b expected 1 %h %h %b 0",
                   it, rf_rw, rf_regnum, rf_datain, done, rf_inc, RNW'(d), res, d == 3'd7);
        else n_pass++;
        if (d != 3'd7) begin
          step();
          n_total++;
          if (rf_inc !== 1'b1 || done !== 1'b1 || rf_rw !== 1'b0)
            $display("FAIL rnd%0d_inc: got inc=%b done=%b rw=%b expected 1 1 0", it, rf_inc, done, rf_rw);
          else n_pass++;
        end
      end else begin
        n_total++;
        if (rf_inc !== 1'b1 || done !== 1'b1 || rf_rw !== 1'b0)
          $display("FAIL rnd%0d_inc: got inc=%b done=%b rw=%b expected 1 1 0", it, rf_inc, done, rf_rw);
        else n_pass++;
      end
      retire_model(d, wb, res);
      step();
      n_total++; if (ready !== 1'b1) $display("FAIL rnd%0d_ready: got %b expected 1", it, ready); else n_pass++;
    end
    check_mem("rnd");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end expected end");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_reg_src_wb();
    test_const_no_wb();
    test_pc_dest();
    test_busy();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_seq.md
# regfile_seq

- Register-file access sequencer on the initiator side of the register-file port.
- For each instruction handed over by decode, it performs these steps in order:
  - read the source operand, either a register R0–R7 or a constant-table entry;
  - read the destination register;
  - present both operands to the ALU and wait for its result;
  - optionally write the result back;
  - increment the PC (R7) by 2.
- It drives the register file's `regnum`/`rw`/`datain`/`inc` inputs and consumes its `dataout`, serialising all accesses through the single port.

## Interface
Parameters:
- `DW`, 16, data width
- `RNW`, 8, register-number width on the register-file port
- `PC_IDX`, 7, register index of the PC

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  decode presents an instruction; accepted only when `ready`=1
- `ready`  out  1  sequencer is idle and accepts `start`
- `src_en`  in  1  instruction has a source operand
- `rc`  in  1  1 = source comes from the constant table (regnum 8+src), 0 = from register `src`
- `src`  in  3  source register or constant index
- `dst`  in  3  destination register
- `wb_en`  in  1  write the result back to `dst`
- `src_val`  out  DW  captured source operand
- `dst_val`  out  DW  captured destination operand
- `ops_valid`  out  1  `src_val`/`dst_val` are valid; the sequencer is waiting for a result
- `res_valid`  in  1  ALU result is present
- `res_data`  in  DW  ALU result
- `done`  out  1  one-cycle pulse when the instruction retires
- `rf_regnum`  out  RNW  register number driven to the register file
- `rf_rw`  out  1  0 = read, 1 = write
- `rf_datain`  out  DW  write data to the register file
- `rf_inc`  out  1  one-cycle PC+2 request
- `rf_dataout`  in  DW  register-file read data, valid exactly 1 cycle after `rf_regnum` is presented with `rf_rw`=0

## Operation
- States: IDLE, RD_SRC, RD_DST, CAP, WAIT_RES, WRITE, INC.
- IDLE:
  - `ready`=1.
  - On `start`, latch `src_en`, `rc`, `src`, `dst` and `wb_en`.
  - Go to RD_SRC if `src_en`=1; otherwise clear `src_val` to 0 and go to RD_DST.
- RD_SRC: drive `rf_regnum`={`RNW`-4 zeros, `rc`, `src`} with `rf_rw`=0. Go to RD_DST.
- RD_DST:
  - Drive `rf_regnum`=`dst` (zero-extended), `rf_rw`=0.
  - If the source was read, capture `rf_dataout` into `src_val`.
  - Go to CAP.
- CAP: capture `rf_dataout` into `dst_val`. Go to WAIT_RES.
- WAIT_RES:
  - `ops_valid`=1.
  - On `res_valid`, register `res_data` into `rf_datain`.
  - Go to WRITE if the latched `wb_en`=1, else INC.
- WRITE:
  - Drive `rf_rw`=1, `rf_regnum`=`dst`, `rf_datain`=result.
  - If `dst`==`PC_IDX`, the write replaces the PC: skip INC, pulse `done`, return to IDLE.
  - Otherwise go to INC.
- INC: `rf_inc`=1 and `done`=1 for one cycle. Go to IDLE.
- `rf_regnum` upper bits are always zero. Constant indices 8–15 are reachable only via `rc`=1 in RD_SRC and are never written.
- `rf_regnum`=0 and `rf_rw`=0 in IDLE, CAP, WAIT_RES and INC.
- `rf_rw`=1 only in WRITE. `rf_rw` and `rf_inc` are never high together.

## Timing
- Reset values:
  - `ready`=1.
  - All other outputs are 0: `ops_valid`, `done`, `rf_rw`, `rf_inc`, `rf_regnum`, `rf_datain`, `src_val`, `dst_val`.
  - State = IDLE.
- Reset mid-instruction:
  - The next cycle is IDLE with reset values.
  - Any pending write or increment is dropped.
- `start` accepted at cycle N:
  - RD_SRC at N+1, RD_DST at N+2, CAP at N+3, `ops_valid` from N+4.
  - With `src_en`=0: RD_DST at N+1, `ops_valid` from N+3.
- `res_valid` sampled at cycle M (with `ops_valid`=1):
  - `wb_en`=1: write at M+1, `rf_inc`/`done` at M+2.
  - `wb_en`=0: `rf_inc`/`done` at M+1.
- `res_valid` outside WAIT_RES is ignored. `start` while `ready`=0 is ignored, with no queuing.
- The next `start` can be accepted in the cycle after `done`.
- The PC adder wraps modulo 2^16; that is the register file's concern, and this block issues `rf_inc` unconditionally.

## Structure
- Package `regfile_seq_pkg` holds:
  - the state enum;
  - the constants `PC_IDX`=7 and `CONST_BASE`=8;
  - the register-number field widths, shared with the register file and decode.
- Single module with no sub-module; the FSM and operand latches together are ~150–200 lines.

## Test plan
- Reset then idle:
  - `ready`=1 and all other outputs 0.
  - Preload R2=0x1234, R3=0x0F0F.
- Register source, `wb_en`=1: `start` with `rc`=0, `src`=2, `dst`=3, `wb_en`=1.
  - `ops_valid` at N+4 with `src_val`=0x1234 and `dst_val`=0x0F0F.
  - `res_valid` with 0x2143 → WRITE regnum 3 data 0x2143 at M+1.
  - `rf_inc` and `done` at M+2.
- Constant source, no writeback: `rc`=1, `src`=7, `wb_en`=0.
  - RD_SRC drives `rf_regnum`=15, giving `src_val`=0xFFFF.
  - No write; `done` at M+1.
- No source, destination = PC: `src_en`=0, `dst`=7, `wb_en`=1, result 0x0100.
  - `src_val`=0 and `ops_valid` at N+3.
  - Write R7=0x0100 with no `rf_inc`; `done` in the WRITE cycle.
- `start` while busy: assert `start` during WAIT_RES with different fields.
  - It is ignored and the operands are unchanged.
  - `res_valid` held high before `ops_valid` does not advance the FSM.
- Reset in WAIT_RES and in WRITE: assert `rst`.
  - IDLE next cycle, no `rf_rw`/`rf_inc` pulse, `ready`=1.
